lsu_axi_master: RTL and testbench

//   AXI4-Lite initiator between the core's load/store unit and the memory/device bus.

---
 rtl/lsu_axi_master.sv | 170 +++++++++++++++++
 tb/tb_lsu_axi_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_axi_master.sv
// AXI4-Lite initiator for the load/store unit: one LSU request becomes one
// AR+R or AW+W+B transaction, and completes with a single response pulse.
module lsu_axi_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // LSU request / response
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_sext,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    // AXI-Lite read channels
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    // AXI-Lite write channels
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              wvalid,
    input  logic              wready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_A = 3'd1;
    localparam logic [2:0] S_RD_D = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_WR_B = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    logic [2:0]        r_state;
    logic              r_aw_done;
    logic              r_w_done;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_wstrb;
    logic [1:0]        r_size;
    logic              r_sext;

    logic              w_req_fire;
    logic              w_misalign;
    logic [3:0]        w_wstrb;
    logic [DATA_W-1:0] w_rshift;
    logic [DATA_W-1:0] w_load;
    logic              w_aw_ok;
    logic              w_w_ok;

    assign w_req_fire = req_valid && req_ready;
    assign w_misalign = (req_size == 2'd3)
                     || (req_size == 2'd1 && req_addr[0])
                     || (req_size == 2'd2 && req_addr[1:0] != 2'b00);

    // NOTE: always_comb gives every output a default first so no latch is inferred.
    always_comb begin
        w_wstrb = 4'b1111;
        case (req_size)
            2'd0:    w_wstrb = 4'b0001 << req_addr[1:0];
            2'd1:    w_wstrb = 4'b0011 << req_addr[1:0];
            default: w_wstrb = 4'b1111;
        endcase
    end

    assign w_rshift = rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load = w_rshift;
        case (r_size)
            2'd0:    w_load = {{24{r_sext & w_rshift[7]}}, w_rshift[7:0]};
            2'd1:    w_load = {{16{r_sext & w_rshift[15]}}, w_rshift[15:0]};
            default: w_load = w_rshift;
        endcase
    end

    // A channel counts as done once its handshake has happened, now or earlier.
    assign w_aw_ok = r_aw_done || awready;
    assign w_w_ok  = r_w_done  || wready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_fire) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_err     <= w_misalign;
                        r_rdata   <= '0;
                        if (w_misalign)   r_state <= S_RESP;
                        else if (req_wen) r_state <= S_WR;
                        else              r_state <= S_RD_A;
                    end
                end
                S_RD_A: if (arready) r_state <= S_RD_D;
                S_RD_D: begin
                    if (rvalid) begin
                        r_rdata <= w_load;
                        r_err   <= (rresp != 2'b00);
                        r_state <= S_RESP;
                    end
                end
                S_WR: begin
                    if (awready) r_aw_done <= 1'b1;
                    if (wready)  r_w_done  <= 1'b1;
                    if (w_aw_ok && w_w_ok) r_state <= S_WR_B;
                end
                S_WR_B: begin
                    if (bvalid) begin
                        r_err   <= (bresp != 2'b00);
                        r_state <= S_RESP;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: request datapath registers carry no reset; they are only read after being loaded.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata << {req_addr[1:0], 3'b000};
            r_wstrb <= w_wstrb;
            r_size  <= req_size;
            r_sext  <= req_sext;
        end
    end

    // Every output is forced low while rst is asserted, independent of the state register.
    assign req_ready  = !rst && (r_state == S_IDLE);
    assign resp_valid = !rst && (r_state == S_RESP);
    assign resp_err   = resp_valid && r_err;
    assign resp_rdata = resp_valid ? r_rdata : '0;

    assign arvalid = !rst && (r_state == S_RD_A);
    assign araddr  = rst ? '0 : r_addr;
    assign rready  = !rst && (r_state == S_RD_D);

    assign awvalid = !rst && (r_state == S_WR) && !r_aw_done;
    assign awaddr  = rst ? '0 : r_addr;
    assign wvalid  = !rst && (r_state == S_WR) && !r_w_done;
    assign wdata   = rst ? '0 : r_wdata;
    assign wstrb   = rst ? 4'b0000 : r_wstrb;
    assign bready  = !rst && (r_state == S_WR_B);

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master with a negedge AXI-Lite responder,
// UART byte sink at 0xA00003F8 and hand-computed expected results.
module tb_lsu_axi_master;

    localparam logic [31:0] UART_ADDR = 32'hA000_03F8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_sext;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] araddr, rdata;
    logic [1:0]  rresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] awaddr, wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;

    lsu_axi_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_sext(req_sext), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Responder knobs and observations
    logic [31:0] rdata_val = '0;
    logic [1:0]  rresp_val = '0, bresp_val = '0;
    logic        r_hold = 1'b0, mon_off = 1'b0;
    int          aw_delay = 0, b_delay = 1;
    int          aw_cnt = 0, b_cnt = 0, aw_only_cnt = 0, resp_cnt = 0, proto_err = 0;
    logic        ever_ar = 1'b0, ever_aw = 1'b0;
    logic [31:0] cap_araddr = '0, cap_awaddr = '0, cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;
    logic [7:0]  uart_byte = '0;
    logic        p_arvalid = 0, p_arready = 0, p_awvalid = 0, p_awready = 0, p_wvalid = 0, p_wready = 0;

    initial begin
        arready = 0; rvalid = 0; rdata = '0; rresp = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0;
    end

    // DUT outputs change only at posedge, so the responder reacts at negedge for the next edge.
    always @(negedge clk) begin
        if (!mon_off && !rst) begin
            if (p_arvalid && !p_arready && !arvalid) proto_err++;
            if (p_awvalid && !p_awready && !awvalid) proto_err++;
            if (p_wvalid  && !p_wready  && !wvalid)  proto_err++;
        end
        if (resp_valid) resp_cnt++;

        arready = arvalid;
        if (arvalid) begin ever_ar = 1'b1; cap_araddr = araddr; end
        rvalid = rready && !r_hold;
        rdata  = rdata_val;
        rresp  = rresp_val;

        wready = wvalid;
        if (wvalid) begin
            ever_aw = 1'b1;
            cap_wdata = wdata;
            cap_wstrb = wstrb;
            if (awaddr == UART_ADDR && wstrb[0]) begin
                uart_byte = wdata[7:0];
                $display("UART: %c", wdata[7:0]);
            end
        end
        if (awvalid) begin
            ever_aw = 1'b1;
            cap_awaddr = awaddr;
            awready = (aw_cnt >= aw_delay);
            aw_cnt++;
            if (!wvalid) aw_only_cnt++;
        end else begin
            awready = 1'b0;
            aw_cnt = 0;
        end

        if (bready) begin
            bvalid = (b_cnt >= b_delay);
            b_cnt++;
        end else begin
            bvalid = 1'b0;
            b_cnt = 0;
        end
        bresp = bresp_val;

        p_arvalid = arvalid; p_arready = arready;
        p_awvalid = awvalid; p_awready = awready;
        p_wvalid  = wvalid;  p_wready  = wready;
    end

    // Issue one request, return cycles from acceptance to resp_valid plus the response.
    task automatic do_req(input string tag, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] size, input logic sext,
                          output int lat, output logic [31:0] rd, output logic err);
        int n;
        lat = 0; rd = '0; err = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_wen = wen; req_addr = addr;
        req_wdata = wd; req_size = size; req_sext = sext;
        #1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready) begin
            check({tag, "_accept_timeout"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            if (resp_valid) begin
                lat = i; rd = resp_rdata; err = resp_err;
                break;
            end
        end
        if (lat == 0) check({tag, "_resp_timeout"}, 32'd0, 32'd1);
        @(negedge clk); #1;
        check({tag, "_ready_after_resp"}, {31'd0, req_ready}, 32'd1);
    endtask

    function automatic logic [31:0] outs_or();
        return {19'd0, |araddr, |awaddr, |wdata, |wstrb, |resp_rdata,
                req_ready, resp_valid, resp_err, arvalid, rready, awvalid, wvalid, bready};
    endfunction

    int          lat, c0;
    logic [31:0] rd;
    logic        err;

    initial begin
        rst = 1'b1; req_valid = 0; req_wen = 0; req_addr = '0;
        req_wdata = '0; req_size = '0; req_sext = 0;
        @(negedge clk); #1;
        check("reset_outputs_zero", outs_or(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_reset", {31'd0, req_ready}, 32'd1);

        // Word load, zero-wait responder
        rdata_val = 32'hDEAD_BEEF; rresp_val = 2'b00;
        do_req("ld_word", 1'b0, 32'h8000_0004, '0, 2'd2, 1'b0, lat, rd, err);
        check("ld_word_araddr", cap_araddr, 32'h8000_0004);
        check("ld_word_data", rd, 32'hDEAD_BEEF);
        check("ld_word_err", {31'd0, err}, 32'd0);
        check("ld_word_latency", lat, 32'd3);

        // Byte and half loads with sign/zero extension
        rdata_val = 32'h80FF_1234;
        do_req("ld_byte_s", 1'b0, 32'h8000_0003, '0, 2'd0, 1'b1, lat, rd, err);
        check("ld_byte_sext", rd, 32'hFFFF_FF80);
        do_req("ld_byte_z", 1'b0, 32'h8000_0003, '0, 2'd0, 1'b0, lat, rd, err);
        check("ld_byte_zext", rd, 32'h0000_0080);
        do_req("ld_half_s", 1'b0, 32'h8000_0002, '0, 2'd1, 1'b1, lat, rd, err);
        check("ld_half_sext", rd, 32'hFFFF_80FF);
        do_req("ld_half_z", 1'b0, 32'h8000_0002, '0, 2'd1, 1'b0, lat, rd, err);
        check("ld_half_zext", rd, 32'h0000_80FF);

        // Byte store to the UART
        c0 = resp_cnt; uart_byte = '0;
        do_req("st_uart", 1'b1, UART_ADDR, 32'h0000_0041, 2'd0, 1'b0, lat, rd, err);
        check("st_uart_wstrb", {28'd0, cap_wstrb}, 32'h1);
        check("st_uart_wdata_lo", {24'd0, cap_wdata[7:0]}, 32'h41);
        check("st_uart_char", {24'd0, uart_byte}, 32'h41);
        check("st_uart_awaddr", cap_awaddr, UART_ADDR);
        check("st_uart_err", {31'd0, err}, 32'd0);
        check("st_uart_rdata", rd, 32'd0);
        check("st_uart_latency", lat, 32'd4);
        check("st_uart_resp_count", resp_cnt - c0, 32'd1);

        // Half store with awready trailing wready by three cycles
        aw_delay = 3; aw_only_cnt = 0;
        do_req("st_half", 1'b1, 32'h8000_0002, 32'h0000_BEEF, 2'd1, 1'b0, lat, rd, err);
        check("st_half_wstrb", {28'd0, cap_wstrb}, 32'hC);
        check("st_half_wdata", cap_wdata, 32'hBEEF_0000);
        check("st_half_aw_alone", aw_only_cnt, 32'd3);
        check("st_half_err", {31'd0, err}, 32'd0);
        check("st_half_latency", lat, 32'd7);
        aw_delay = 0;

        // Misaligned and reserved-size requests never touch the bus
        ever_ar = 1'b0; ever_aw = 1'b0;
        do_req("mis_word", 1'b0, 32'h8000_0001, '0, 2'd2, 1'b0, lat, rd, err);
        check("mis_word_err", {31'd0, err}, 32'd1);
        check("mis_word_latency", lat, 32'd1);
        do_req("size3", 1'b1, 32'h8000_0000, 32'h1234_5678, 2'd3, 1'b0, lat, rd, err);
        check("size3_err", {31'd0, err}, 32'd1);
        check("size3_latency", lat, 32'd1);
        check("mis_no_bus", {30'd0, ever_ar, ever_aw}, 32'd0);

        // Reset while waiting in RD_D abandons the load
        r_hold = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0008; req_size = 2'd2; req_sext = 1'b0;
        for (int i = 0; i < 20 && !rready; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
        end
        req_valid = 1'b0;
        check("rd_d_reached", {31'd0, rready}, 32'd1);
        mon_off = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_reset_outputs_zero", outs_or(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        r_hold = 1'b0;
        c0 = resp_cnt;
        repeat (3) @(negedge clk);
        #1;
        mon_off = 1'b0;
        check("post_reset_no_resp", resp_cnt - c0, 32'd0);
        check("post_reset_valids", {29'd0, arvalid, awvalid, wvalid}, 32'd0);
        check("post_reset_ready", {31'd0, req_ready}, 32'd1);

        // Store answered with SLVERR
        bresp_val = 2'b10;
        do_req("st_slverr", 1'b1, 32'h8000_0010, 32'hCAFE_F00D, 2'd2, 1'b0, lat, rd, err);
        check("st_slverr_err", {31'd0, err}, 32'd1);
        check("st_slverr_wdata", cap_wdata, 32'hCAFE_F00D);
        bresp_val = 2'b00;

        check("protocol_valid_hold", proto_err, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
